mem_io_bridge: RTL and testbench
================================

# mem_io_bridge

Parametrised memory/IO bridge between the SLC-3 datapath and the external asynchronous SRAM. It replaces the fixed-width Mem2IO plus ISDU-timed SRAM strobes. The bridge accepts single read/write requests over a Req/Ready handshake and decodes a memory-mapped IO address (switch input, hex display register). It also generates active-low SRAM strobes with a configurable number of wait states. It sits between the CPU datapath (MAR/MDR) and the top-level tristate buffer.

## Interface
Parameters:
- DATA_W, 16, data word width
- CPU_ADDR_W, 16, CPU address width
- ADDR_W, 20, SRAM address width; must be >= CPU_ADDR_W
- WAIT_STATES, 1, extra SRAM access cycles (0..15)
- NUM_HEX, 4, hex digits shown; NUM_HEX*4 <= DATA_W
- IO_ADDR, all-ones of CPU_ADDR_W, memory-mapped IO address

Ports:
- Clk  in  1  sole clock, rising edge
- Reset  in  1  synchronous, active-high
- Req  in  1  request strobe, sampled in IDLE only
- Write  in  1  1 = write, 0 = read; sampled with Req
- Addr  in  CPU_ADDR_W  request address
- Wdata  in  DATA_W  write data
- Ready  out  1  one-cycle completion pulse
- Rdata  out  DATA_W  read result, valid while Ready is high and held until the next completion
- Switches  in  DATA_W  board switches, readable at IO_ADDR
- Hex_seg  out  NUM_HEX x 7  seven-segment outputs, digit 0 = least-significant nibble
- ADDR  out  ADDR_W  SRAM address, Addr zero-extended
- CE, UB, LB, OE, WE  out  1 each  SRAM strobes, active-low
- Data_to_SRAM  out  DATA_W  write data to the tristate buffer
- Data_from_SRAM  in  DATA_W  read data from the tristate buffer
- Drive_en  out  1  tristate output enable, high only while writing

## Operation
- States: IDLE, ACCESS, DONE. Codes are in the shared package.
- IDLE: when Req=1, latch Addr, Write, Wdata and (with the macro enabled) Byte_en.
  - If Addr == IO_ADDR, go to DONE directly:
    - read: Rdata <= Switches
    - write: hex_reg <= Wdata[NUM_HEX*4-1:0]
    - no SRAM strobe is asserted.
  - Otherwise load wait_cnt <= WAIT_STATES and go to ACCESS.
- ACCESS:
  - CE=0. ADDR holds the latched address.
  - Read: OE=0, WE=1.
  - Write: WE=0, OE=1, Drive_en=1, Data_to_SRAM = latched Wdata.
  - wait_cnt decrements each cycle. When wait_cnt==0: on a read, Rdata <= Data_from_SRAM; then go to DONE.
- DONE: Ready=1 and all strobes are high (deasserted). Next state is IDLE unconditionally.
- Req outside IDLE is ignored and not queued. The requester need not hold Addr/Wdata after the accept cycle.
- Hex_seg[i] is a combinational decode of hex_reg[4i+3:4i] to 0-9, A-F.
- Reset, including mid-access: state returns to IDLE and the following are cleared:
  - hex_reg = 0, Rdata = 0, Ready = 0
  - CE/UB/LB/OE/WE = 1, Drive_en = 0, ADDR = 0
  - an in-flight write is abandoned.

## Timing
- Ready is asserted in cycle WAIT_STATES+2 for SRAM accesses and in cycle 1 for IO accesses, where cycle 0 is the IDLE cycle with Req=1.
- ACCESS lasts exactly WAIT_STATES+1 cycles. The strobes are stable for that whole window and are registered, so they are glitch-free.
- The earliest next accept is the cycle after DONE. Peak throughput is therefore one request per WAIT_STATES+3 cycles (SRAM) or 2 cycles (IO).
- Hex_seg updates in the cycle after the DONE edge of an IO write.

## Configuration
- MEMIO_BYTE_LANE_EN defined: adds input Byte_en [1:0], latched with Req.
  - During ACCESS: LB = ~Byte_en[0], UB = ~Byte_en[1].
  - Byte_en=2'b00 on an SRAM request completes through ACCESS with no lane enabled.
  - IO writes ignore Byte_en.
- Undefined: no Byte_en port; UB=LB=0 throughout ACCESS.

## Structure
- Package memio_pkg holds:
  - the state enum
  - a function for the default IO address
  - the seven-segment lookup constant
- One sub-module, hex_digit_decoder (4-bit in, 7-bit out), instantiated NUM_HEX times in a generate loop.
- Parameter legality is checked with elaboration-time assertions.

## Test plan
- WAIT_STATES=1, read Addr=0x0010 with SRAM model returning 0xBEEF -> OE low cycles 1-2, Ready high in cycle 3, Rdata=0xBEEF, ADDR=0x00010.
- Write Addr=0x1234, Wdata=0x00A5 -> WE low and Drive_en high for exactly 2 cycles, Data_to_SRAM=0x00A5, OE stays high, Ready in cycle 3.
- Write IO_ADDR=0xFFFF, Wdata=0x3C7F -> Ready in cycle 1, no CE pulse, Hex_seg decodes to digits 3,C,7,F; then read IO_ADDR with Switches=0x0042 -> Rdata=0x0042 in cycle 1.
- WAIT_STATES=3, Req held high continuously -> accepts at cycles 0, 6, 12; Ready at cycles 5, 11.
- Reset asserted in the second ACCESS cycle of a write -> next cycle WE=1, Drive_en=0, Ready=0, hex_reg=0, state IDLE; a new Req is accepted the cycle after Reset drops.
- MEMIO_BYTE_LANE_EN, write with Byte_en=2'b10 -> UB=0 and LB=1 during ACCESS.

Source files
------------

// File: rtl/memio_pkg.sv
// Shared types and constants for the memory/IO bridge: FSM state codes,
// default IO address helper and the seven-segment lookup table.
package memio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Returns the all-ones address for a CPU address width (1..32 bits).
  function automatic logic [31:0] default_io_addr(input int width);
    return (32'h1 << width) - 32'h1;
  endfunction

  // Active-low segments {g,f,e,d,c,b,a}, indexed by the nibble value.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/mem_io_bridge_hex.sv
// Single hex digit to seven-segment decoder used for the display register.
module hex_digit_decoder
  import memio_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_LUT[nibble_i];

endmodule

// File: rtl/mem_io_bridge.sv
// SLC-3 memory/IO bridge: Req/Ready handshake, memory-mapped switches/hex
// display and registered SRAM strobes. MEMIO_BYTE_LANE_EN adds Byte_en.
module mem_io_bridge
  import memio_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int CPU_ADDR_W  = 16,
  parameter int ADDR_W      = 20,
  parameter int WAIT_STATES = 1,
  parameter int NUM_HEX     = 4,
  parameter logic [CPU_ADDR_W-1:0] IO_ADDR = CPU_ADDR_W'(default_io_addr(CPU_ADDR_W))
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Req,
  input  logic                  Write,
  input  logic [CPU_ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0]     Wdata,
`ifdef MEMIO_BYTE_LANE_EN
  input  logic [1:0]            Byte_en,
`endif
  output logic                  Ready,
  output logic [DATA_W-1:0]     Rdata,
  input  logic [DATA_W-1:0]     Switches,
  output logic [NUM_HEX*7-1:0]  Hex_seg,
  output logic [ADDR_W-1:0]     ADDR,
  output logic                  CE,
  output logic                  UB,
  output logic                  LB,
  output logic                  OE,
  output logic                  WE,
  output logic [DATA_W-1:0]     Data_to_SRAM,
  input  logic [DATA_W-1:0]     Data_from_SRAM,
  output logic                  Drive_en
);

  if (ADDR_W < CPU_ADDR_W) begin : g_chk_addr
    $error("mem_io_bridge: ADDR_W must be >= CPU_ADDR_W");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_chk_wait
    $error("mem_io_bridge: WAIT_STATES must be in 0..15");
  end
  if (NUM_HEX < 1 || NUM_HEX * 4 > DATA_W) begin : g_chk_hex
    $error("mem_io_bridge: NUM_HEX must be >= 1 and NUM_HEX*4 <= DATA_W");
  end

  state_e                  state_q, state_d;
  logic                    wr_q, wr_d;
  logic [CPU_ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [3:0]              wait_q, wait_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic [NUM_HEX*4-1:0]    hex_q, hex_d;
  logic                    ready_q, ready_d;
  logic                    ce_q, ce_d, oe_q, oe_d, we_q, we_d;
  logic                    ub_q, ub_d, lb_q, lb_d;
  logic                    drive_q, drive_d;
  logic                    in_access;
`ifdef MEMIO_BYTE_LANE_EN
  logic [1:0]              be_q, be_d;
`endif

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wait_d  = wait_q;
    rdata_d = rdata_q;
    hex_d   = hex_q;
`ifdef MEMIO_BYTE_LANE_EN
    be_d    = be_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (Req) begin
          wr_d    = Write;
          addr_d  = Addr;
          wdata_d = Wdata;
`ifdef MEMIO_BYTE_LANE_EN
          be_d    = Byte_en;
`endif
          if (Addr == IO_ADDR) begin
            state_d = ST_DONE;
            if (Write) hex_d = Wdata[NUM_HEX*4-1:0];
            else       rdata_d = Switches;
          end else begin
            wait_d  = 4'(WAIT_STATES);
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (wait_q == 4'd0) begin
          if (!wr_q) rdata_d = Data_from_SRAM;
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobes are derived from the next state so they are registered and
    // span exactly the ACCESS window without glitches.
    in_access = (state_d == ST_ACCESS);
    ce_d      = !in_access;
    oe_d      = !(in_access && !wr_d);
    we_d      = !(in_access && wr_d);
    drive_d   = in_access && wr_d;
    ready_d   = (state_d == ST_DONE);
`ifdef MEMIO_BYTE_LANE_EN
    lb_d      = !(in_access && be_d[0]);
    ub_d      = !(in_access && be_d[1]);
`else
    lb_d      = !in_access;
    ub_d      = !in_access;
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wait_q  <= '0;
      rdata_q <= '0;
      hex_q   <= '0;
      ready_q <= 1'b0;
      ce_q    <= 1'b1;
      oe_q    <= 1'b1;
      we_q    <= 1'b1;
      ub_q    <= 1'b1;
      lb_q    <= 1'b1;
      drive_q <= 1'b0;
`ifdef MEMIO_BYTE_LANE_EN
      be_q    <= 2'b00;
`endif
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wait_q  <= wait_d;
      rdata_q <= rdata_d;
      hex_q   <= hex_d;
      ready_q <= ready_d;
      ce_q    <= ce_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      ub_q    <= ub_d;
      lb_q    <= lb_d;
      drive_q <= drive_d;
`ifdef MEMIO_BYTE_LANE_EN
      be_q    <= be_d;
`endif
    end
  end

  for (genvar i = 0; i < NUM_HEX; i++) begin : g_hex
    hex_digit_decoder u_dec (
      .nibble_i (hex_q[4*i +: 4]),
      .seg_o    (Hex_seg[7*i +: 7])
    );
  end

  assign Ready        = ready_q;
  assign Rdata        = rdata_q;
  assign ADDR         = ADDR_W'(addr_q);
  assign CE           = ce_q;
  assign OE           = oe_q;
  assign WE           = we_q;
  assign UB           = ub_q;
  assign LB           = lb_q;
  assign Drive_en     = drive_q;
  assign Data_to_SRAM = wdata_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge; a WAIT_STATES=3 instance shares the inputs
// and is checked in the back-to-back scenario.
module tb_mem_io_bridge;
  import memio_pkg::*;

  localparam logic [6:0] V_IDLE = 7'b1111100; // {CE,OE,WE,UB,LB,Drive_en,Ready}
  localparam logic [6:0] V_RD   = 7'b0010000;
  localparam logic [6:0] V_WR   = 7'b0100010;
  localparam logic [6:0] V_DONE = 7'b1111101;

  logic        Clk = 1'b0;
  logic        Reset, Req, Write;
  logic [15:0] Addr, Wdata, Switches, Data_from_SRAM;
  logic [1:0]  Byte_en;

  logic        Ready, CE, UB, LB, OE, WE, Drive_en;
  logic [15:0] Rdata, Data_to_SRAM;
  logic [27:0] Hex_seg;
  logic [19:0] ADDR;

  logic        Ready3, CE3, UB3, LB3, OE3, WE3, Drive_en3;
  logic [15:0] Rdata3, Data_to_SRAM3;
  logic [27:0] Hex_seg3;
  logic [19:0] ADDR3;

  int n_checks = 0;
  int n_fail   = 0;

  wire [6:0] v1 = {CE, OE, WE, UB, LB, Drive_en, Ready};

  always #5 Clk = ~Clk;

  mem_io_bridge #(.WAIT_STATES(1)) u_dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Write(Write), .Addr(Addr), .Wdata(Wdata),
`ifdef MEMIO_BYTE_LANE_EN
    .Byte_en(Byte_en),
`endif
    .Ready(Ready), .Rdata(Rdata), .Switches(Switches), .Hex_seg(Hex_seg), .ADDR(ADDR),
    .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE), .Data_to_SRAM(Data_to_SRAM),
    .Data_from_SRAM(Data_from_SRAM), .Drive_en(Drive_en)
  );

  mem_io_bridge #(.WAIT_STATES(3)) u_dut3 (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Write(Write), .Addr(Addr), .Wdata(Wdata),
`ifdef MEMIO_BYTE_LANE_EN
    .Byte_en(Byte_en),
`endif
    .Ready(Ready3), .Rdata(Rdata3), .Switches(Switches), .Hex_seg(Hex_seg3), .ADDR(ADDR3),
    .CE(CE3), .UB(UB3), .LB(LB3), .OE(OE3), .WE(WE3), .Data_to_SRAM(Data_to_SRAM3),
    .Data_from_SRAM(Data_from_SRAM), .Drive_en(Drive_en3)
  );

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge Clk);
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    idle_cycles(2);
    n_checks++;
    if (v1 !== V_IDLE) begin
      n_fail++; $display("FAIL reset_strobes got=%b want=%b", v1, V_IDLE);
    end
    n_checks++;
    if (Rdata !== 16'h0 || ADDR !== 20'h0) begin
      n_fail++; $display("FAIL reset_regs rdata=%h addr=%h want 0/0", Rdata, ADDR);
    end
    n_checks++;
    if (Hex_seg !== {4{7'h40}}) begin
      n_fail++; $display("FAIL reset_hex got=%h want=%h", Hex_seg, {4{7'h40}});
    end
    Reset = 1'b0;
  endtask

  task automatic test_sram_read;
    logic [6:0] exp;
    @(negedge Clk);
    Req = 1'b1; Write = 1'b0; Addr = 16'h0010;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) begin
        @(negedge Clk);
        Req = 1'b0; Addr = 16'h5555;
      end
      exp = (c == 1 || c == 2) ? V_RD : (c == 3) ? V_DONE : V_IDLE;
      n_checks++;
      if (v1 !== exp) begin
        n_fail++; $display("FAIL read_strobes c%0d got=%b want=%b", c, v1, exp);
      end
      if (c == 1) begin
        n_checks++;
        if (ADDR !== 20'h00010) begin
          n_fail++; $display("FAIL read_addr got=%h want=00010", ADDR);
        end
      end
      if (c >= 3) begin
        n_checks++;
        if (Rdata !== 16'hBEEF) begin
          n_fail++; $display("FAIL read_data c%0d got=%h want=beef", c, Rdata);
        end
      end
    end
  endtask

  task automatic test_sram_write;
    logic [6:0] exp;
    @(negedge Clk);
    Req = 1'b1; Write = 1'b1; Addr = 16'h1234; Wdata = 16'h00A5;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) begin
        @(negedge Clk);
        Req = 1'b0; Wdata = 16'hFFFF;
      end
      exp = (c == 1 || c == 2) ? V_WR : (c == 3) ? V_DONE : V_IDLE;
      n_checks++;
      if (v1 !== exp) begin
        n_fail++; $display("FAIL write_strobes c%0d got=%b want=%b", c, v1, exp);
      end
      if (c == 1 || c == 2) begin
        n_checks++;
        if (Data_to_SRAM !== 16'h00A5 || ADDR !== 20'h01234) begin
          n_fail++; $display("FAIL write_bus c%0d data=%h addr=%h want 00a5/01234", c, Data_to_SRAM, ADDR);
        end
      end
    end
  endtask

  task automatic test_io;
    logic [6:0] exp;
    @(negedge Clk);
    Req = 1'b1; Write = 1'b1; Addr = 16'hFFFF; Wdata = 16'h3C7F;
    for (int c = 0; c <= 2; c++) begin
      if (c > 0) begin
        @(negedge Clk);
        Req = 1'b0;
      end
      exp = (c == 1) ? V_DONE : V_IDLE;
      n_checks++;
      if (v1 !== exp) begin
        n_fail++; $display("FAIL io_write_strobes c%0d got=%b want=%b", c, v1, exp);
      end
    end
    n_checks++;
    if (Hex_seg !== {7'h30, 7'h46, 7'h78, 7'h0E}) begin
      n_fail++; $display("FAIL io_hex got=%h want=%h", Hex_seg, {7'h30, 7'h46, 7'h78, 7'h0E});
    end
    Req = 1'b1; Write = 1'b0; Addr = 16'hFFFF; Switches = 16'h0042;
    @(negedge Clk);
    Req = 1'b0;
    n_checks++;
    if (v1 !== V_DONE || Rdata !== 16'h0042) begin
      n_fail++; $display("FAIL io_read strobes=%b rdata=%h want %b/0042", v1, Rdata, V_DONE);
    end
    @(negedge Clk);
  endtask

  task automatic test_reset_mid_access;
    @(negedge Clk);
    Req = 1'b1; Write = 1'b1; Addr = 16'h2000; Wdata = 16'h1111;
    @(negedge Clk);
    Req = 1'b0;
    @(negedge Clk);
    n_checks++;
    if (v1 !== V_WR) begin
      n_fail++; $display("FAIL mid_pre_reset got=%b want=%b", v1, V_WR);
    end
    Reset = 1'b1;
    @(negedge Clk);
    n_checks++;
    if (v1 !== V_IDLE || u_dut.state_q !== ST_IDLE) begin
      n_fail++; $display("FAIL mid_reset strobes=%b state=%0d want %b/0", v1, u_dut.state_q, V_IDLE);
    end
    n_checks++;
    if (Hex_seg !== {4{7'h40}}) begin
      n_fail++; $display("FAIL mid_reset_hex got=%h want=%h", Hex_seg, {4{7'h40}});
    end
    Reset = 1'b0;
    Req = 1'b1; Write = 1'b0; Addr = 16'h0010;
    @(negedge Clk);
    Req = 1'b0;
    n_checks++;
    if (v1 !== V_RD) begin
      n_fail++; $display("FAIL post_reset_accept got=%b want=%b", v1, V_RD);
    end
    idle_cycles(8);
  endtask

  task automatic test_back_to_back;
    logic exp_r3, exp_ce3, exp_r1;
    @(negedge Clk);
    Req = 1'b1; Write = 1'b0; Addr = 16'h0020;
    for (int c = 0; c <= 13; c++) begin
      if (c > 0) @(negedge Clk);
      exp_r3  = (c == 5 || c == 11);
      exp_ce3 = !((c >= 1 && c <= 4) || (c >= 7 && c <= 10) || c == 13);
      exp_r1  = (c == 3 || c == 7 || c == 11);
      n_checks++;
      if (Ready3 !== exp_r3 || CE3 !== exp_ce3 || Ready !== exp_r1) begin
        n_fail++;
        $display("FAIL b2b c%0d ready3=%b ce3=%b ready1=%b want %b/%b/%b",
                 c, Ready3, CE3, Ready, exp_r3, exp_ce3, exp_r1);
      end
    end
    Req = 1'b0;
    idle_cycles(8);
  endtask

`ifdef MEMIO_BYTE_LANE_EN
  task automatic test_byte_lane;
    @(negedge Clk);
    Req = 1'b1; Write = 1'b1; Addr = 16'h0040; Wdata = 16'hAB00; Byte_en = 2'b10;
    @(negedge Clk);
    Req = 1'b0; Byte_en = 2'b11;
    for (int c = 1; c <= 2; c++) begin
      if (c > 1) @(negedge Clk);
      n_checks++;
      if (UB !== 1'b0 || LB !== 1'b1 || WE !== 1'b0) begin
        n_fail++; $display("FAIL byte_lane c%0d ub=%b lb=%b we=%b want 0/1/0", c, UB, LB, WE);
      end
    end
    idle_cycles(8);
  endtask
`endif

  initial begin
    Reset = 1'b1; Req = 1'b0; Write = 1'b0; Addr = '0; Wdata = '0;
    Switches = 16'h0000; Data_from_SRAM = 16'hBEEF; Byte_en = 2'b11;
    test_reset;
    test_sram_read;
    test_sram_write;
    test_io;
    test_reset_mid_access;
    test_back_to_back;
`ifdef MEMIO_BYTE_LANE_EN
    test_byte_lane;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
